// File: rtl/rk_step_scaler.sv
// rk_step_scaler: iterative signed power-of-two scaler for the RK datapath.
// Multiplies (dir=0) or arithmetically divides (dir=1) a signed operand by 2^k.
// It applies one single-bit shift per clock and uses a start/busy/done handshake.
//
// Ports:
//   clk      - system clock, rising edge
//   clr      - synchronous active-high reset; aborts any operation in flight
//   start    - request, sampled only while idle
//   data_in  - signed operand, latched on accept
//   amount   - shift count k, latched on accept
//   dir      - 0 = left (x 2^k), 1 = right (floor / 2^k), latched on accept
//   busy     - high whenever the block is not idle
//   done     - one-cycle pulse; data_out/ovf valid in this cycle
//   data_out - signed result, held until the next done
//   ovf      - sticky left-shift overflow flag for the current result
module rk_step_scaler #(
  parameter int unsigned N  = 32,
  parameter int unsigned SW = 5
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [N-1:0]  data_in,
  input  logic [SW-1:0] amount,
  input  logic          dir,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  data_out,
  output logic          ovf
);

  typedef enum logic [1:0] {
    s_idle  = 2'd0,
    s_shift = 2'd1,
    s_done  = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  w;
  logic [SW-1:0] cnt;
  logic          dir_q;
  logic          ovf_int;

  logic [N-1:0]  w_step_c;
  logic          ovf_step_c;

  // One shift step of the working register, plus the sticky overflow update.
  // A left step overflows when the two top bits differ before the shift.
  always_comb begin
    w_step_c   = w;
    ovf_step_c = ovf_int;
    if (dir_q) begin
      w_step_c = {w[N-1], w[N-1:1]};
    end else begin
      w_step_c   = {w[N-2:0], 1'b0};
      ovf_step_c = ovf_int | (w[N-1] ^ w[N-2]);
    end
  end

  // Control FSM with registered handshake outputs.
  // Results are captured on the edge that enters DONE, so the final shift's
  // value is taken from the step logic rather than from w.
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= s_idle;
      w        <= '0;
      cnt      <= '0;
      dir_q    <= 1'b0;
      ovf_int  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        s_idle: begin
          if (start) begin
            w       <= data_in;
            cnt     <= amount;
            dir_q   <= dir;
            ovf_int <= 1'b0;
            busy    <= 1'b1;
            if (amount == SW'(0)) begin
              state    <= s_done;
              done     <= 1'b1;
              data_out <= data_in;
              ovf      <= 1'b0;
            end else begin
              state <= s_shift;
            end
          end
        end
        s_shift: begin
          w       <= w_step_c;
          cnt     <= cnt - SW'(1);
          ovf_int <= ovf_step_c;
          if (cnt == SW'(1)) begin
            state    <= s_done;
            done     <= 1'b1;
            data_out <= w_step_c;
            ovf      <= ovf_step_c;
          end
        end
        s_done: begin
          state <= s_idle;
          busy  <= 1'b0;
        end
        default: begin
          state <= s_idle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
